// File: rtl/barrel8_shift_sched_pkg.sv
// Shared constants, FSM state encoding and per-pass step helper for the barrel8 scheduler.
package barrel_sched_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned AMT_W    = 4;
    localparam int unsigned MAX_STEP = 7;
    localparam int unsigned STEP_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One pass moves at most MAX_STEP positions; the remainder is left for later passes.
    function automatic logic [STEP_W-1:0] step_of(input logic [AMT_W-1:0] rem);
        return (rem > AMT_W'(MAX_STEP)) ? STEP_W'(MAX_STEP) : rem[STEP_W-1:0];
    endfunction

endpackage

// File: rtl/barrel8_shift_sched_barrel8.sv
// Combinational 8-bit logical barrel shifter, zero fill, 0..7 positions per call.
module barrel8
    import barrel_sched_pkg::*;
(
    input  logic [DATA_W-1:0] start,
    input  logic [STEP_W-1:0] shift,
    input  logic              right,
    output logic [DATA_W-1:0] result
);

    assign result = right ? (start >> shift) : (start << shift);

endmodule

// File: rtl/barrel8_shift_sched.sv
// Round-robin scheduler sharing one barrel8 between two requesters; multi-pass for amounts up to 15.
module barrel8_shift_sched
    import barrel_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [AMT_W-1:0]  req0_amt,
    input  logic              req0_right,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [AMT_W-1:0]  req1_amt,
    input  logic              req1_right,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id
);

    state_t             state;
    logic [DATA_W-1:0]  acc;
    logic [AMT_W-1:0]   rem;
    logic               dir;
    logic               id;
    logic               last_grant;

    logic               any_req;
    logic               grant;
    logic [DATA_W-1:0]  sel_data;
    logic [AMT_W-1:0]   sel_amt;
    logic               sel_right;
    logic [STEP_W-1:0]  step;
    logic [DATA_W-1:0]  result;

    // Round-robin: on a tie the requester that did not win last time is granted.
    always_comb begin
        any_req   = req0_valid | req1_valid;
        grant     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        sel_data  = grant ? req1_data  : req0_data;
        sel_amt   = grant ? req1_amt   : req0_amt;
        sel_right = grant ? req1_right : req0_right;
        step      = step_of(rem);
    end

    assign req0_ready = !rst && (state == IDLE) && any_req && !grant;
    assign req1_ready = !rst && (state == IDLE) && any_req &&  grant;

    barrel8 u_barrel8 (
        .start  (acc),
        .shift  (step),
        .right  (dir),
        .result (result)
    );

    // rsp_valid is raised one cycle after entering DONE, capturing acc/id into the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            rem        <= '0;
            dir        <= 1'b0;
            id         <= 1'b0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        acc        <= sel_data;
                        rem        <= sel_amt;
                        dir        <= sel_right;
                        id         <= grant;
                        last_grant <= grant;
                        state      <= (sel_amt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= result;
                    rem <= rem - AMT_W'(step);
                    if (rem == AMT_W'(step)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= acc;
                        rsp_id    <= id;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_barrel8_shift_sched.sv
// Directed and randomized bench for barrel8_shift_sched against a behavioural shift/arbitration model.
module tb_barrel8_shift_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic [3:0] req0_amt, req1_amt;
    logic       req0_right, req1_right;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_id;

    int n_cmp = 0;
    int n_bad = 0;
    logic m_last = 1'b1;

    always #5 clk = ~clk;

    barrel8_shift_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_right (req0_right),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_right (req1_right),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // A single logical shift by the full amount, zero fill; 8 or more clears the byte.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int a, input logic r);
        int unsigned x;
        x = 32'(d);
        x = r ? (x >> a) : ((x << a) & 32'hFF);
        return 8'(x);
    endfunction

    task automatic job(input logic v0, input logic v1,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic r0, input logic r1,
                       input bit keep, input int stall);
        logic       g;
        logic [7:0] exp_d;
        int         amt;
        int         exp_lat;
        int         lat;
        @(negedge clk);
        req0_valid = v0; req0_data = d0; req0_amt = a0; req0_right = r0;
        req1_valid = v1; req1_data = d1; req1_amt = a1; req1_right = r1;
        rsp_ready  = (stall == 0);
        #1;
        g = (v0 && v1) ? !m_last : v1;
        check("ready0", 32'(req0_ready), 32'(!g));
        check("ready1", 32'(req1_ready), 32'(g));
        m_last  = g;
        amt     = g ? int'(a1) : int'(a0);
        exp_d   = ref_shift(g ? d1 : d0, amt, g ? r1 : r0);
        exp_lat = 1 + (amt + 6) / 7;
        @(posedge clk); #1;
        if (!keep) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        lat = 0;
        while (!rsp_valid && lat < 12) begin
            check("busy_ready", 32'(req0_ready | req1_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("rsp_data", 32'(rsp_data), 32'(exp_d));
        check("rsp_id", 32'(rsp_id), 32'(g));
        for (int i = 0; i < stall; i++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            @(posedge clk); #1;
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_data", 32'(rsp_data), 32'(exp_d));
            check("stall_id", 32'(rsp_id), 32'(g));
            check("stall_ready", 32'(req0_ready | req1_ready), 32'd0);
        end
        if (stall > 0) begin
            req0_valid = keep ? v0 : 1'b0;
            req1_valid = keep ? v1 : 1'b0;
            rsp_ready  = 1'b1;
        end
        @(posedge clk); #1;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_data = 8'hAA; req0_amt = 4'd3; req0_right = 1'b0;
        req1_valid = 1'b1; req1_data = 8'h55; req1_amt = 4'd3; req1_right = 1'b0;
        rsp_ready  = 1'b0;
        #2;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_data", 32'(rsp_data), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_ready", 32'(req0_ready | req1_ready), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Basic right/left shifts and the zero-amount shortcut.
        job(1, 0, 8'hF0, 8'h00, 4'd2, 4'd0, 1, 0, 0, 0);
        job(0, 1, 8'h00, 8'hF0, 4'd0, 4'd2, 0, 0, 0, 0);
        job(0, 1, 8'h00, 8'h81, 4'd0, 4'd0, 0, 0, 0, 0);

        // Both requesters held valid: grants alternate.
        for (int i = 0; i < 4; i++) begin
            job(1, 1, 8'h0F, 8'h0F, 4'd1, 4'd1, 0, 0, 1, 0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Multi-pass amounts, requester 0 served back to back.
        job(1, 0, 8'h80, 8'h00, 4'd7, 4'd0, 1, 0, 0, 0);
        job(1, 0, 8'hFF, 8'h00, 4'd9, 4'd0, 0, 0, 0, 0);
        job(1, 0, 8'hFF, 8'h00, 4'd15, 4'd0, 1, 0, 0, 0);
        job(1, 0, 8'h01, 8'h00, 4'd14, 4'd0, 0, 0, 0, 0);

        // Consumer back-pressure for five cycles, then resume.
        job(0, 1, 8'h00, 8'h96, 4'd0, 4'd3, 0, 1, 0, 5);
        job(1, 0, 8'h3C, 8'h00, 4'd4, 4'd0, 0, 0, 0, 0);

        // Reset in the middle of a 15-position job.
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 8'hFF; req0_amt = 4'd15; req0_right = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        #1;
        check("mid_ready0", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_ready", 32'(req0_ready | req1_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0;
        m_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("post_rst_valid", 32'(rsp_valid), 32'd0);
        end
        job(1, 1, 8'hC3, 8'h5A, 4'd5, 4'd2, 1, 0, 0, 0);

        // Randomized jobs.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] v;
            v = 2'($urandom_range(1, 3));
            job(v[0], v[1], 8'($urandom), 8'($urandom), 4'($urandom), 4'($urandom),
                1'($urandom), 1'($urandom), 0, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
